// File: rtl/and2_test_ctrl.sv
// Board-side controller for the and2 gate: debounced manual drive of the gate
// from S1/S2, plus a hold-both-switches self-test with the verdict on the LEDs.
module and2_test_ctrl #(
  parameter int DEB_CYCLES    = 500_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int STEP_CYCLES   = 16,
  parameter int RESULT_CYCLES = 100_000_000,
  parameter int BLINK_HALF    = 12_500_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw_s1,
  input  logic       i_sw_s2,
  output logic       o_gate_a,
  output logic       o_gate_b,
  input  logic       i_gate_y,
  output logic       o_led_done,
  output logic       o_led_ready,
  output logic [1:0] o_dbg_state
);

  localparam int DW = (DEB_CYCLES    > 1) ? $clog2(DEB_CYCLES)    : 1;
  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int SW = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
  localparam int RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam int BW = (BLINK_HALF    > 1) ? $clog2(BLINK_HALF)    : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_CYCLES - 1);
  localparam logic [RW-1:0] RESULT_LAST = RW'(RESULT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_ARM    = 2'd1,
    ST_TEST   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    sync1, sync2, deb, deb_nxt;
  logic [DW-1:0] deb_cnt [2];
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] step_cnt;
  logic [RW-1:0] result_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    idx;
  logic          fail;
  logic          mismatch;

  assign o_dbg_state = state;
  assign mismatch    = (i_gate_y != (idx[1] & idx[0]));

  // Bit 0 is S1, bit 1 is S2. deb_nxt lets the gate outputs flip on the same
  // edge as the debounced value rather than one cycle later.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] != deb[i] && deb_cnt[i] == DEB_LAST) deb_nxt[i] = sync2[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {i_sw_s2, i_sw_s1};
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i] || deb_cnt[i] == DEB_LAST) deb_cnt[i] <= '0;
        else                                              deb_cnt[i] <= deb_cnt[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_MANUAL;
      hold_cnt    <= '0;
      step_cnt    <= '0;
      result_cnt  <= '0;
      blink_cnt   <= '0;
      idx         <= '0;
      fail        <= 1'b0;
      o_gate_a    <= 1'b0;
      o_gate_b    <= 1'b0;
      o_led_done  <= 1'b0;
      o_led_ready <= 1'b0;
    end else begin
      case (state)
        ST_MANUAL: begin
          o_gate_a    <= deb_nxt[0];
          o_gate_b    <= deb_nxt[1];
          o_led_done  <= i_gate_y;
          o_led_ready <= 1'b0;
          if (&deb) begin
            state    <= ST_ARM;
            hold_cnt <= '0;
          end
        end
        ST_ARM: begin
          o_gate_a    <= deb_nxt[0];
          o_gate_b    <= deb_nxt[1];
          o_led_done  <= i_gate_y;
          o_led_ready <= 1'b0;
          if (!(&deb)) begin
            state    <= ST_MANUAL;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_TEST;
            hold_cnt <= '0;
            idx      <= '0;
            step_cnt <= '0;
            fail     <= 1'b0;
            o_gate_a <= 1'b0;
            o_gate_b <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_TEST: begin
          o_led_done  <= i_gate_y;
          o_led_ready <= 1'b0;
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            fail     <= fail | mismatch;
            if (idx == 2'd3) begin
              state       <= ST_RESULT;
              result_cnt  <= '0;
              blink_cnt   <= '0;
              o_gate_a    <= 1'b0;
              o_gate_b    <= 1'b0;
              o_led_done  <= fail | mismatch;
              o_led_ready <= 1'b1;
            end else begin
              idx                  <= idx + 2'd1;
              {o_gate_a, o_gate_b} <= idx + 2'd1;
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
        ST_RESULT: begin
          o_gate_a   <= 1'b0;
          o_gate_b   <= 1'b0;
          o_led_done <= fail;
          if (result_cnt != RESULT_LAST) result_cnt <= result_cnt + RW'(1);
          if (fail) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt   <= '0;
              o_led_ready <= ~o_led_ready;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end else begin
            o_led_ready <= 1'b1;
          end
          // Requiring both switches released stops a still-held pair from re-arming.
          if (result_cnt == RESULT_LAST && deb == 2'b00) begin
            state       <= ST_MANUAL;
            result_cnt  <= '0;
            blink_cnt   <= '0;
            o_gate_a    <= deb_nxt[0];
            o_gate_b    <= deb_nxt[1];
            o_led_done  <= i_gate_y;
            o_led_ready <= 1'b0;
          end
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_and2_test_ctrl.sv
// Directed bench for and2_test_ctrl with small parameters and a behavioural and2
// that can be forced stuck-at-0.
module tb_and2_test_ctrl;

  localparam int DEB    = 4;
  localparam int HOLD   = 8;
  localparam int STEP   = 4;
  localparam int RESULT = 16;
  localparam int BLINK  = 2;

  localparam logic [1:0] S_MANUAL = 2'd0;
  localparam logic [1:0] S_TEST   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_s1 = 1'b0;
  logic       sw_s2 = 1'b0;
  logic       fault = 1'b0;
  logic       gate_a, gate_b, gate_y, led_done, led_ready;
  logic [1:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign gate_y = fault ? 1'b0 : (gate_a & gate_b);

  and2_test_ctrl #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP),
    .RESULT_CYCLES(RESULT), .BLINK_HALF(BLINK)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_s1(sw_s1), .i_sw_s2(sw_s2),
    .o_gate_a(gate_a), .o_gate_b(gate_b), .i_gate_y(gate_y),
    .o_led_done(led_done), .o_led_ready(led_ready), .o_dbg_state(dbg_state)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; sw_s1 = 1'b0; sw_s2 = 1'b0; fault = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    ok = (dbg_state === s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    tests_run++;
    if ({gate_a, gate_b, led_done, led_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0000", {gate_a, gate_b, led_done, led_ready});
    end
    tests_run++;
    if (dbg_state !== S_MANUAL) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, S_MANUAL);
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    bit seen_high = 1'b0;
    apply_reset();
    sw_s1 = 1'b1;
    tick(3);
    sw_s1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (gate_a !== 1'b0) seen_high = 1'b1;
      tick(1);
    end
    tests_run++;
    if (seen_high) begin
      tests_failed++;
      $display("FAIL glitch_filtered: got gate_a=1 want gate_a=0 throughout");
    end
    sw_s1 = 1'b1;
    tick(5);
    tests_run++;
    if (gate_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL deb_edge_early: got %b want 0 five cycles after raw edge", gate_a);
    end
    tick(1);
    tests_run++;
    if (gate_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL deb_edge_latency: got %b want 1 six cycles after raw edge", gate_a);
    end
  endtask

  task automatic test_manual();
    bit entered_test = 1'b0;
    int n = 0;
    apply_reset();
    sw_s1 = 1'b1; sw_s2 = 1'b1;
    while (!(gate_a === 1'b1 && gate_b === 1'b1) && n < 20) begin
      tick(1);
      n++;
    end
    tests_run++;
    if ({gate_a, gate_b} !== 2'b11) begin
      tests_failed++;
      $display("FAIL manual_gate_11: got %b want 11", {gate_a, gate_b});
    end
    tick(1);
    tests_run++;
    if (led_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL manual_done_high: got %b want 1", led_done);
    end
    sw_s2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_state === S_TEST) entered_test = 1'b1;
      tick(1);
    end
    tests_run++;
    if (entered_test) begin
      tests_failed++;
      $display("FAIL manual_no_test: got TEST entry want none");
    end
    tests_run++;
    if ({gate_a, gate_b, led_done, led_ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL manual_s2_low: got %b want 1000", {gate_a, gate_b, led_done, led_ready});
    end
  endtask

  task automatic test_selftest_pass();
    bit ok;
    logic [1:0] exp_vec;
    logic       exp_done;
    apply_reset();
    sw_s1 = 1'b1; sw_s2 = 1'b1;
    wait_state(S_TEST, 60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL pass_enter_test: got state %0d want %0d", dbg_state, S_TEST);
    end
    for (int k = 0; k < 16; k++) begin
      exp_vec = 2'(k / 4);
      tests_run++;
      if ({gate_a, gate_b} !== exp_vec) begin
        tests_failed++;
        $display("FAIL pass_vector[%0d]: got %b want %b", k, {gate_a, gate_b}, exp_vec);
      end
      if (k >= 1) begin
        exp_done = ((k - 1) / 4 == 3);
        tests_run++;
        if (led_done !== exp_done) begin
          tests_failed++;
          $display("FAIL pass_done_follow[%0d]: got %b want %b", k, led_done, exp_done);
        end
      end
      tick(1);
    end
    tests_run++;
    if (dbg_state !== S_RESULT) begin
      tests_failed++;
      $display("FAIL pass_enter_result: got %0d want %0d", dbg_state, S_RESULT);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({led_done, led_ready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL pass_leds[%0d]: got %b want 01", i, {led_done, led_ready});
      end
      tick(1);
    end
  endtask

  task automatic test_selftest_fail_and_exit();
    bit ok;
    logic [7:0] exp_ready;
    exp_ready = 8'b00110011;  // bit i = expected o_led_ready i cycles after entry
    apply_reset();
    fault = 1'b1;
    sw_s1 = 1'b1; sw_s2 = 1'b1;
    wait_state(S_RESULT, 80, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fail_enter_result: got state %0d want %0d", dbg_state, S_RESULT);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({led_done, led_ready} !== {1'b1, exp_ready[i]}) begin
        tests_failed++;
        $display("FAIL fail_blink[%0d]: got %b want %b", i, {led_done, led_ready}, {1'b1, exp_ready[i]});
      end
      tick(1);
    end
    tick(12);
    tests_run++;
    if (dbg_state !== S_RESULT) begin
      tests_failed++;
      $display("FAIL held_stays_result: got %0d want %0d", dbg_state, S_RESULT);
    end
    sw_s1 = 1'b0; sw_s2 = 1'b0;
    wait_state(S_MANUAL, 30, ok);
    tests_run++;
    if (!ok || {gate_a, gate_b, led_done, led_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL release_to_manual: got state %0d outs %b want state 0 outs 0000",
               dbg_state, {gate_a, gate_b, led_done, led_ready});
    end
  endtask

  task automatic test_reset_mid_test();
    bit ok;
    int n = 0;
    apply_reset();
    sw_s1 = 1'b1; sw_s2 = 1'b1;
    wait_state(S_TEST, 60, ok);
    while (!(dbg_state === S_TEST && gate_a === 1'b1 && gate_b === 1'b0) && n < 30) begin
      tick(1);
      n++;
    end
    tests_run++;
    if (!(dbg_state === S_TEST && {gate_a, gate_b} === 2'b10)) begin
      tests_failed++;
      $display("FAIL abort_reach_idx2: got state %0d gate %b want state 2 gate 10",
               dbg_state, {gate_a, gate_b});
    end
    rst = 1'b1;
    tick(1);
    tests_run++;
    if (dbg_state !== S_MANUAL || {gate_a, gate_b, led_done, led_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_reset: got state %0d outs %b want state 0 outs 0000",
               dbg_state, {gate_a, gate_b, led_done, led_ready});
    end
    rst = 1'b0;
    sw_s1 = 1'b0; sw_s2 = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_manual();
    test_selftest_pass();
    test_selftest_fail_and_exit();
    test_reset_mid_test();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
